// File: rtl/gcd_controller_pkg.sv
// gcd_controller_pkg: state encodings and datapath mux select codes shared by the GCD controller.
package gcd_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_ITER   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic SEL_A    = 1'b0;
    localparam logic SEL_B    = 1'b1;
    localparam logic SEL_DATA = 1'b1;
    localparam logic SEL_SUB  = 1'b0;

endpackage

// File: rtl/gcd_controller_if.sv
// gcd_controller_if: host handshake, datapath flags and datapath controls of the GCD controller.
interface gcd_controller_if;

    logic start;
    logic data_valid;
    logic data_req;
    logic gt;
    logic lt;
    logic eq;
    logic ldA;
    logic ldB;
    logic sel1;
    logic sel2;
    logic sel_in;
    logic busy;
    logic done;
    logic err;

    modport master (
        input  start, data_valid, gt, lt, eq,
        output data_req, ldA, ldB, sel1, sel2, sel_in, busy, done, err
    );

    modport slave (
        output start, data_valid, gt, lt, eq,
        input  data_req, ldA, ldB, sel1, sel2, sel_in, busy, done, err
    );

endinterface

// File: rtl/gcd_controller_iter_watchdog.sv
// gcd_controller_iter_watchdog: counts ITER cycles and flags when MAX_ITER is reached.
module gcd_controller_iter_watchdog #(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [ITER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end

    assign expired = cnt == ITER_W'(MAX_ITER);

endmodule

// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for the subtractive GCD datapath; optional watchdog under GCD_TIMEOUT_EN.
module gcd_controller
    import gcd_controller_pkg::*;
#(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input logic             clk,
    input logic             rst,
    gcd_controller_if.master bus
);

    if (MAX_ITER < 1 || MAX_ITER > (1 << ITER_W) - 1) begin : g_bad_max_iter
        $error("MAX_ITER out of range for ITER_W");
    end

    state_t state, next;
    logic   expired;
    logic   in_load, iter, sub_a, sub_b;

`ifdef GCD_TIMEOUT_EN
    gcd_controller_iter_watchdog #(
        .ITER_W  (ITER_W),
        .MAX_ITER(MAX_ITER)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != S_ITER),
        .inc    (state == S_ITER),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        state <= rst ? S_IDLE : next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: next = bus.start ? S_LOAD_A : state;
            S_LOAD_A:              next = bus.data_valid ? S_LOAD_B : state;
            S_LOAD_B:              next = bus.data_valid ? S_ITER : state;
            S_ITER:                next = bus.eq ? S_DONE : expired ? S_ERR : S_ITER;
            default:               next = S_IDLE;
        endcase
    end

    // eq outranks gt, gt outranks lt; no flag set means hold
    always_comb begin
        in_load      = state == S_LOAD_A || state == S_LOAD_B;
        iter         = state == S_ITER;
        sub_a        = iter && !bus.eq && bus.gt;
        sub_b        = iter && !bus.eq && !bus.gt && bus.lt;
        bus.data_req = in_load;
        bus.sel_in   = in_load ? SEL_DATA : SEL_SUB;
        bus.ldA      = (state == S_LOAD_A && bus.data_valid) || sub_a;
        bus.ldB      = (state == S_LOAD_B && bus.data_valid) || sub_b;
        bus.sel1     = sub_b ? SEL_B : SEL_A;
        bus.sel2     = sub_a ? SEL_B : SEL_A;
        bus.busy     = in_load || iter;
        bus.done     = state == S_DONE;
        bus.err      = state == S_ERR;
    end

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed bench driving gcd_controller with a behavioural 16-bit subtractive datapath.
module tb_gcd_controller;

`ifdef GCD_TIMEOUT_EN
    localparam int MI = 8;
`else
    localparam int MI = 65535;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcd_controller_if g ();

    gcd_controller #(.ITER_W(16), .MAX_ITER(MI)) dut (
        .clk(clk),
        .rst(rst),
        .bus(g)
    );

    logic [15:0] ra = '0, rb = '0, data_in = '0;
    logic [15:0] x, y, dbus;
    logic [8:0]  outs;
    logic        start = 1'b0, dv = 1'b0;

    assign g.start      = start;
    assign g.data_valid = dv;
    assign x            = g.sel1 ? rb : ra;
    assign y            = g.sel2 ? rb : ra;
    assign dbus         = g.sel_in ? data_in : x - y;
    assign g.gt         = ra > rb;
    assign g.lt         = ra < rb;
    assign g.eq         = ra == rb;
    assign outs = {g.data_req, g.ldA, g.ldB, g.sel1, g.sel2, g.sel_in, g.busy, g.done, g.err};

    always @(posedge clk) begin
        if (g.ldA) ra <= dbus;
        if (g.ldB) rb <= dbus;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // edges are counted from the edge that accepts start
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input int k,
                       input int stall, input bit poke, input logic [15:0] res);
        int n, ld;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        data_in = a;
        repeat (stall) begin
            chk({tag, "_stall"}, {g.data_req, g.ldA, g.busy}, 3'b101);
            @(negedge clk);
        end
        dv = 1'b1;
        #1 chk({tag, "_load_a"}, {g.data_req, g.ldA, g.sel_in}, 3'b111);
        @(negedge clk) data_in = b;
        @(negedge clk) dv = 1'b0;
        n  = 2 + stall;
        ld = 0;
        while (!g.done && n < 3 + k + stall + 5) begin
            ld += int'(g.ldA || g.ldB);
            start = poke && n == 3 + stall;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, 3 + k + stall);
        chk({tag, "_subs"}, ld, k);
        chk({tag, "_result"}, ra, res);
        chk({tag, "_busy_err"}, {g.busy, g.err}, 2'b00);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset", outs, 0);
        rst = 1'b0;
        run("t1", 16'd48, 16'd18, 4, 0, 1'b0, 16'd6);
        run("t2", 16'd7, 16'd7, 0, 0, 1'b0, 16'd7);
        run("t3", 16'd21, 16'd14, 2, 5, 1'b0, 16'd7);
        run("t4_start", 16'd48, 16'd18, 4, 0, 1'b1, 16'd6);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        data_in = 16'd0;
        dv = 1'b1;
        @(negedge clk) data_in = 16'd5;
        @(negedge clk) dv = 1'b0;
        n = 0;
`ifdef GCD_TIMEOUT_EN
        while (!g.err && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t5_err", {g.err, g.busy, g.ldA, g.ldB}, 4'b1000);
`else
        repeat (100) begin
            n += int'(g.busy);
            @(negedge clk);
        end
        chk("t5_busy", n, 100);
        chk("t5_err", g.err, 1'b0);
`endif
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("t4_rst", outs, 0);
        run("t4_after_rst", 16'd21, 16'd14, 2, 0, 1'b0, 16'd7);
`ifndef GCD_TIMEOUT_EN
        run("t6", 16'd1, 16'd65535, 65534, 0, 1'b0, 16'd1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
